book_snapshot_tx: RTL and testbench

Avalon-ST source that serializes one order-book snapshot into a 64-bit packet toward the HPS-side FIFO/DMA. It is the transmit counterpart of the streamer's packet sink, using the same start/end/valid/empty/ready framing. On a capture request it latches the top `DEPTH` ask and bid levels plus the security ID into shadow registers. It then streams a header, the levels and an optional trailer, honouring backpressure.

---
 rtl/book_snapshot_tx.sv | 188 ++++++++++++++++++
 tb/tb_book_snapshot_tx.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/book_snapshot_tx.sv
// book_snapshot_tx: captures one order-book snapshot and streams it as a 64-bit Avalon-ST packet.
// Latency: header beat valid one cycle after snap_req; then one beat per accepted cycle.
// Backpressure: beat (data/sop/eop) holds while valid && !ready; ready has no combinational path to data_out.
//
// Optional feature macro: BOOK_SNAPSHOT_TRAILER_EN adds a {seq, checksum} trailer beat.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   snap_req            one-cycle capture request (ignored and counted while busy)
//   security_id         32-bit ID sampled with snap_req
//   levels              DEPTH*256 bits: ask i at [i*128 +: 128], bid i at [(DEPTH+i)*128 +: 128]
//   ready               sink ready, ready latency 0
//   data_out, valid     beat data / valid
//   start_packet        first beat (header)
//   end_packet          last beat
//   empty               always 0, every beat is full
//   busy                snapshot held or in transmission
//   drop_count          rejected requests, saturating
module book_snapshot_tx #(
  parameter int DEPTH = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   snap_req,
  input  logic [31:0]            security_id,
  input  logic [DEPTH*256-1:0]   levels,
  input  logic                   ready,
  output logic [63:0]            data_out,
  output logic                   valid,
  output logic                   start_packet,
  output logic                   end_packet,
  output logic [2:0]             empty,
  output logic                   busy,
  output logic [15:0]            drop_count
);

  localparam int NB = 4 * DEPTH;             // payload beats
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
`ifdef BOOK_SNAPSHOT_TRAILER_EN
  localparam int BT = NB + 2;                // header + payload + trailer
`else
  localparam int BT = NB + 1;                // header + payload
`endif

  typedef struct packed {
    logic [31:0] sec_id;
    logic [7:0]  magic;
    logic [7:0]  depth;
    logic [15:0] beat_total;
  } hdr_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD
`ifdef BOOK_SNAPSHOT_TRAILER_EN
    , S_TRAILER
`endif
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;                        // payload beat currently on data_out
  logic [63:0]   shadow [NB];                // captured levels as 64-bit words
  hdr_t          hdr;
  logic          accept;
  logic          last_pay;
  logic [IW-1:0] nxt_idx;
  logic [63:0]   nxt_word;

  assign empty    = 3'd0;
  assign accept   = valid && ready;
  assign last_pay = (idx == IW'(NB - 1));
  assign nxt_idx  = idx + IW'(1);
  // Each level goes out upper half first, so payload beat p is stored word p^1.
  assign nxt_word = shadow[nxt_idx ^ IW'(1)];

  assign hdr = '{sec_id:     security_id,
                 magic:      8'hA5,
                 depth:      8'(DEPTH),
                 beat_total: 16'(BT)};

`ifdef BOOK_SNAPSHOT_TRAILER_EN
  logic [31:0] seq;
  logic [31:0] csum;
  logic [31:0] csum_nxt;
  assign csum_nxt = csum ^ data_out[63:32] ^ data_out[31:0];
`endif

  // Shadow copy is only written from IDLE, so a packet in flight never sees live data.
  always_ff @(posedge clk) begin
    if (!reset && state == S_IDLE && snap_req) begin
      for (int k = 0; k < NB; k++) begin
        shadow[k] <= levels[k*64 +: 64];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      idx          <= '0;
      data_out     <= '0;
      valid        <= 1'b0;
      start_packet <= 1'b0;
      end_packet   <= 1'b0;
      busy         <= 1'b0;
      drop_count   <= '0;
`ifdef BOOK_SNAPSHOT_TRAILER_EN
      seq          <= '0;
      csum         <= '0;
`endif
    end else begin
      // busy is still high in the final-beat cycle, so a request there is dropped too.
      if (snap_req && busy && drop_count != 16'hFFFF) begin
        drop_count <= drop_count + 16'd1;
      end

      case (state)
        S_IDLE: begin
          if (snap_req) begin
            state        <= S_HEADER;
            data_out     <= hdr;
            valid        <= 1'b1;
            start_packet <= 1'b1;
            end_packet   <= 1'b0;
            busy         <= 1'b1;
            idx          <= '0;
`ifdef BOOK_SNAPSHOT_TRAILER_EN
            csum         <= '0;
`endif
          end
        end

        S_HEADER: begin
          if (accept) begin
            state        <= S_PAYLOAD;
            data_out     <= shadow[IW'(1)];
            start_packet <= 1'b0;
            idx          <= '0;
          end
        end

        S_PAYLOAD: begin
          if (accept) begin
`ifdef BOOK_SNAPSHOT_TRAILER_EN
            csum <= csum_nxt;
`endif
            if (last_pay) begin
`ifdef BOOK_SNAPSHOT_TRAILER_EN
              state      <= S_TRAILER;
              data_out   <= {seq, csum_nxt};
              end_packet <= 1'b1;
`else
              state      <= S_IDLE;
              data_out   <= '0;
              valid      <= 1'b0;
              end_packet <= 1'b0;
              busy       <= 1'b0;
`endif
            end else begin
              idx      <= nxt_idx;
              data_out <= nxt_word;
`ifndef BOOK_SNAPSHOT_TRAILER_EN
              end_packet <= (nxt_idx == IW'(NB - 1));
`endif
            end
          end
        end

`ifdef BOOK_SNAPSHOT_TRAILER_EN
        S_TRAILER: begin
          if (accept) begin
            state      <= S_IDLE;
            seq        <= seq + 32'd1;
            data_out   <= '0;
            valid      <= 1'b0;
            end_packet <= 1'b0;
            busy       <= 1'b0;
          end
        end
`endif

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_book_snapshot_tx.sv
// Directed bench for book_snapshot_tx (DEPTH=10): basic packet, backpressure,
// rejected requests, shadow isolation, mid-packet reset and, when
// BOOK_SNAPSHOT_TRAILER_EN is defined, back-to-back packets with trailer.
module tb_book_snapshot_tx;
  localparam int DEPTH = 10;
  localparam int NB    = 4 * DEPTH;
`ifdef BOOK_SNAPSHOT_TRAILER_EN
  localparam int BT = NB + 2;
  localparam logic [63:0] HDR_1234 = 64'h0000_1234_A50A_002A;
`else
  localparam int BT = NB + 1;
  localparam logic [63:0] HDR_1234 = 64'h0000_1234_A50A_0029;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 snap_req;
  logic [31:0]          security_id;
  logic [DEPTH*256-1:0] levels;
  logic                 ready;
  logic [63:0]          data_out;
  logic                 valid;
  logic                 start_packet;
  logic                 end_packet;
  logic [2:0]           empty;
  logic                 busy;
  logic [15:0]          drop_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] got_dat [BT];
  logic        got_sop [BT];
  logic        got_eop [BT];
  int          got_n;
  int          empty_bad;
  logic [31:0] exp_seq;

  book_snapshot_tx #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .snap_req(snap_req), .security_id(security_id),
    .levels(levels), .ready(ready), .data_out(data_out), .valid(valid),
    .start_packet(start_packet), .end_packet(end_packet), .empty(empty),
    .busy(busy), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DEPTH*256-1:0] basic_levels();
    logic [DEPTH*256-1:0] v = '0;
    for (int i = 0; i < DEPTH; i++) begin
      v[i*128 +: 128]         = {64'hA0 + 64'(i), 64'hA100 + 64'(i)};
      v[(DEPTH+i)*128 +: 128] = {64'hB0 + 64'(i), 64'hB100 + 64'(i)};
    end
    return v;
  endfunction

  // Expected payload beat p for the basic pattern: level p/2, upper half first.
  function automatic logic [63:0] pay(int p);
    int L = p / 2;
    logic [63:0] hi, lo;
    if (L < DEPTH) begin
      hi = 64'hA0 + 64'(L);   lo = 64'hA100 + 64'(L);
    end else begin
      hi = 64'hB0 + 64'(L - DEPTH); lo = 64'hB100 + 64'(L - DEPTH);
    end
    return (p % 2 == 0) ? hi : lo;
  endfunction

  function automatic logic [63:0] exp_beat(int k, logic [31:0] sec, logic [31:0] seq);
    logic [31:0] x = '0;
    logic [63:0] w;
    if (k == 0) return {sec, 8'hA5, 8'(DEPTH), 16'(BT)};
    if (k <= NB) return pay(k - 1);
    for (int p = 0; p < NB; p++) begin
      w = pay(p);
      x = x ^ w[63:32] ^ w[31:0];
    end
    return {seq, x};
  endfunction

  // Pulse snap_req, then confirm the header is up the following cycle.
  task automatic start_req(input string tag, input logic [31:0] sec);
    security_id = sec;
    snap_req    = 1'b1;
    step();
    snap_req    = 1'b0;
    check_eq({tag, "_hdr_valid"}, 64'(valid), 64'd1);
    check_eq({tag, "_hdr_busy"},  64'(busy),  64'd1);
  endtask

  // Collects one packet from the current sample point. mode 1 = stall pattern.
  // Returns at the sample point after the final acceptance (or after a reset if abort_at hits).
  task automatic run_pkt(input int mode, input int req_at, input bit req_last, input bit mutate,
                         input int abort_at, output int cycles, output int stalls, output int unstable);
    int          k = 0;
    int          s3 = 0;
    bit          prev_stall = 1'b0;
    bit          req_done = 1'b0;
    bit          r;
    logic [65:0] cur, prev;
    cycles = 0; stalls = 0; unstable = 0; empty_bad = 0; prev = '0;
    for (int i = 0; i < BT; i++) begin
      got_dat[i] = '0; got_sop[i] = 1'b0; got_eop[i] = 1'b0;
    end
    while (k < BT && cycles < 400) begin
      snap_req = 1'b0;
      if (abort_at >= 0 && k == abort_at) begin
        reset = 1'b1; ready = 1'b1;
        step();
        reset = 1'b0;
        got_n = k;
        return;
      end
      if (mutate) begin
        for (int i = 0; i < DEPTH * 8; i++) levels[i*32 +: 32] = $urandom();
        security_id = $urandom();
      end
      r = 1'b1;
      if (mode == 1) begin
        if (k == 5 && s3 < 3 && valid) begin
          r = 1'b0; s3++;
        end else if (s3 >= 3) begin
          r = (cycles % 2 == 0);
        end
      end
      if (req_at >= 0 && k == req_at && !req_done) begin
        snap_req = 1'b1; req_done = 1'b1;
      end
      if (req_last && k == BT - 1 && r && valid) snap_req = 1'b1;
      cur = {start_packet, end_packet, data_out};
      if (valid && prev_stall && cur !== prev) unstable++;
      if (valid && empty !== 3'd0) empty_bad++;
      if (valid && r) begin
        got_dat[k] = data_out; got_sop[k] = start_packet; got_eop[k] = end_packet;
        k++;
      end
      prev_stall = valid && !r;
      if (valid && !r) stalls++;
      prev  = cur;
      ready = r;
      cycles++;
      step();
    end
    snap_req = 1'b0;
    ready    = 1'b1;
    got_n    = k;
  endtask

  task automatic check_pkt(input string tag, input logic [31:0] sec, input logic [31:0] seq);
    int bad = 0;
    for (int k = 0; k < BT; k++) begin
      if (got_dat[k] !== exp_beat(k, sec, seq) || got_sop[k] !== (k == 0) ||
          got_eop[k] !== (k == BT - 1)) bad++;
    end
    check_eq({tag, "_len"},       64'(got_n),     64'(BT));
    check_eq({tag, "_bad_beats"}, 64'(bad),       64'd0);
    check_eq({tag, "_empty"},     64'(empty_bad), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, st, un;
    reset = 1'b1; snap_req = 1'b0; ready = 1'b1; security_id = '0;
    levels = basic_levels(); exp_seq = '0;
    step(); step(); step();
    reset = 1'b0;
    step();
    check_eq("rst_valid", 64'(valid),        64'd0);
    check_eq("rst_busy",  64'(busy),         64'd0);
    check_eq("rst_sop",   64'(start_packet), 64'd0);
    check_eq("rst_eop",   64'(end_packet),   64'd0);
    check_eq("rst_data",  data_out,          64'd0);
    check_eq("rst_empty", 64'(empty),        64'd0);
    check_eq("rst_drop",  64'(drop_count),   64'd0);

    // Basic packet, ready held high.
    start_req("basic", 32'h1234);
    run_pkt(0, -1, 1'b0, 1'b0, -1, cyc, st, un);
    check_pkt("basic", 32'h1234, exp_seq);
    check_eq("basic_beat0",  got_dat[0],  HDR_1234);
    check_eq("basic_beat1",  got_dat[1],  64'hA0);
    check_eq("basic_beat2",  got_dat[2],  64'hA100);
    check_eq("basic_beat40", got_dat[40], 64'hB109);
    check_eq("basic_cycles", 64'(cyc),    64'(BT));
    check_eq("basic_done_valid", 64'(valid), 64'd0);
    check_eq("basic_done_busy",  64'(busy),  64'd0);
    exp_seq++;

    // Backpressure.
    start_req("bp", 32'h1234);
    run_pkt(1, -1, 1'b0, 1'b0, -1, cyc, st, un);
    check_pkt("bp", 32'h1234, exp_seq);
    check_eq("bp_stalled",  64'(st >= 3),  64'd1);
    check_eq("bp_cycles",   64'(cyc),      64'(BT + st));
    check_eq("bp_unstable", 64'(un),       64'd0);
    exp_seq++;

    // Rejected requests at beat 10 and in the final-acceptance cycle, then a retry.
    start_req("rej", 32'hBEEF);
    run_pkt(0, 10, 1'b1, 1'b0, -1, cyc, st, un);
    check_pkt("rej", 32'hBEEF, exp_seq);
    exp_seq++;
    security_id = 32'h5678;
    snap_req    = 1'b1;
    check_eq("rej_m1_valid", 64'(valid), 64'd0);
    check_eq("rej_m1_busy",  64'(busy),  64'd0);
    step();
    snap_req = 1'b0;
    check_eq("rej_m2_valid", 64'(valid),        64'd1);
    check_eq("rej_m2_sop",   64'(start_packet), 64'd1);
    check_eq("rej_m2_hdr",   data_out, {32'h5678, 8'hA5, 8'(DEPTH), 16'(BT)});
    check_eq("rej_drop",     64'(drop_count),   64'd2);
    run_pkt(0, -1, 1'b0, 1'b0, -1, cyc, st, un);
    check_pkt("rej2", 32'h5678, exp_seq);
    exp_seq++;

    // Shadow isolation: inputs scrambled every cycle after capture.
    start_req("shadow", 32'hCAFE);
    run_pkt(0, -1, 1'b0, 1'b1, -1, cyc, st, un);
    levels = basic_levels();
    check_pkt("shadow", 32'hCAFE, exp_seq);
    exp_seq++;

    // Reset at beat 20.
    start_req("abort", 32'h4321);
    run_pkt(0, -1, 1'b0, 1'b0, 20, cyc, st, un);
    check_eq("abort_valid", 64'(valid),      64'd0);
    check_eq("abort_busy",  64'(busy),       64'd0);
    check_eq("abort_drop",  64'(drop_count), 64'd0);
    check_eq("abort_eop",   64'(end_packet), 64'd0);
    exp_seq = '0;
    start_req("post_rst", 32'h1234);
    run_pkt(0, -1, 1'b0, 1'b0, -1, cyc, st, un);
    check_pkt("post_rst", 32'h1234, exp_seq);
    exp_seq++;

`ifdef BOOK_SNAPSHOT_TRAILER_EN
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_seq = '0;
    start_req("tr1", 32'h1234);
    run_pkt(0, -1, 1'b0, 1'b0, -1, cyc, st, un);
    check_pkt("tr1", 32'h1234, 32'd0);
    check_eq("tr1_hdr_total", 64'(got_dat[0][15:0]),     64'h002A);
    check_eq("tr1_seq",       64'(got_dat[BT-1][63:32]), 64'd0);
    check_eq("tr1_pay_eop",   64'(got_eop[BT-2]),        64'd0);
    start_req("tr2", 32'h1234);
    run_pkt(0, -1, 1'b0, 1'b0, -1, cyc, st, un);
    check_pkt("tr2", 32'h1234, 32'd1);
    check_eq("tr2_seq",       64'(got_dat[BT-1][63:32]), 64'd1);
    check_eq("tr2_csum",      64'(got_dat[BT-1][31:0]),  64'(exp_beat(BT-1, 32'h0, 32'h0)));
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
